// File: rtl/gf_pkg.sv
// GF(2^8) field definitions shared by the RS/BCH datapath blocks.
// Field multiply reduces by the primitive polynomial x^8+x^4+x^3+x^2+1.
package gf_pkg;

  localparam int unsigned SYMB_WIDTH     = 8;
  localparam int unsigned T_LEN          = 8;
  localparam int unsigned FF_STEP__CHIEN = 2;
  localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11D;

  // Shift-and-add multiply with reduction on every carry out of the MSB.
  function automatic logic [SYMB_WIDTH-1:0] gf_mult(input logic [SYMB_WIDTH-1:0] a,
                                                    input logic [SYMB_WIDTH-1:0] b);
    logic [SYMB_WIDTH-1:0] prod;
    logic [SYMB_WIDTH-1:0] sh;
    prod = '0;
    sh   = a;
    for (int i = 0; i < int'(SYMB_WIDTH); i++) begin
      if (b[i]) prod = prod ^ sh;
      sh = sh[SYMB_WIDTH-1] ? ((sh << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0]) : (sh << 1);
    end
    return prod;
  endfunction

endpackage

// File: rtl/gf_poly_eval_pipe_pkg.sv
// Elaboration helpers for the pipelined polynomial evaluator.
package gf_poly_eval_pipe_pkg;

  function automatic int unsigned pipe_lat(input int unsigned deg, input int unsigned step);
    return (deg + step - 1) / step;
  endfunction

  // Index of the last Horner stage feeding register slice s.
  function automatic int unsigned slice_end(input int unsigned s, input int unsigned deg,
                                            input int unsigned step);
    return ((s + 1) * step < deg) ? (s + 1) * step : deg;
  endfunction

endpackage

// File: rtl/gf_poly_eval_pipe_if.sv
// Coefficient-load, evaluation-point and result streams of gf_poly_eval_pipe.
interface gf_poly_eval_pipe_if
  import gf_pkg::*;
#(
  parameter int unsigned DEG     = T_LEN,
  parameter int unsigned PAR_NUM = 1
);

  logic                                  poly_vld_i;
  logic                                  poly_rdy_o;
  logic [DEG:0][SYMB_WIDTH-1:0]          poly_i;
  logic                                  symb_vld_i;
  logic                                  symb_rdy_o;
  logic [PAR_NUM-1:0][SYMB_WIDTH-1:0]    symb_i;
  logic                                  symb_last_i;
  logic                                  eval_vld_o;
  logic                                  eval_rdy_i;
  logic [PAR_NUM-1:0][SYMB_WIDTH-1:0]    eval_o;
  logic [PAR_NUM-1:0]                    eval_zero_o;
  logic                                  eval_last_o;
  logic                                  busy_o;

  modport slave (
    input  poly_vld_i, poly_i, symb_vld_i, symb_i, symb_last_i, eval_rdy_i,
    output poly_rdy_o, symb_rdy_o, eval_vld_o, eval_o, eval_zero_o, eval_last_o, busy_o
  );

  modport master (
    output poly_vld_i, poly_i, symb_vld_i, symb_i, symb_last_i, eval_rdy_i,
    input  poly_rdy_o, symb_rdy_o, eval_vld_o, eval_o, eval_zero_o, eval_last_o, busy_o
  );

endinterface

// File: rtl/gf_horner_stage.sv
// One Horner step for PAR_NUM lanes: acc_o = acc_i * x_i + coef_i over GF(2^m).
module gf_horner_stage
  import gf_pkg::*;
#(
  parameter int unsigned PAR_NUM = 1
) (
  input  logic [SYMB_WIDTH-1:0]              coef_i,
  input  logic [PAR_NUM-1:0][SYMB_WIDTH-1:0] acc_i,
  input  logic [PAR_NUM-1:0][SYMB_WIDTH-1:0] x_i,
  output logic [PAR_NUM-1:0][SYMB_WIDTH-1:0] acc_o
);

  for (genvar p = 0; p < PAR_NUM; p++) begin : g_lane
    assign acc_o[p] = gf_mult(acc_i[p], x_i[p]) ^ coef_i;
  end

endmodule

// File: rtl/gf_poly_eval_pipe.sv
// Pipelined Horner evaluator: PAR_NUM points per beat against a stored polynomial,
// with a register slice every FF_STEP stages and whole-pipe stall on backpressure.
module gf_poly_eval_pipe
  import gf_pkg::*;
  import gf_poly_eval_pipe_pkg::*;
#(
  parameter int unsigned DEG     = T_LEN,
  parameter int unsigned PAR_NUM = 1,
  parameter int unsigned FF_STEP = FF_STEP__CHIEN
) (
  input logic                 aclk,
  input logic                 areset,
  gf_poly_eval_pipe_if.slave  bus
);

  localparam int unsigned L     = pipe_lat(DEG, FF_STEP);
  localparam int unsigned CNT_W = $clog2(L + 2);

  typedef logic [PAR_NUM-1:0][SYMB_WIDTH-1:0] lanes_t;
  typedef logic [DEG:0][SYMB_WIDTH-1:0]       coef_t;

  coef_t              coef_q, coef_d;
  logic [L-1:0]       vld_q, vld_d, last_q, last_d;
  lanes_t             x_q [L];
  lanes_t             x_d [L];
  lanes_t             acc_q [L];
  lanes_t             acc_d [L];
  logic [PAR_NUM-1:0] zero_q, zero_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  lanes_t st_acc_in [1:DEG];
  lanes_t st_x      [1:DEG];
  lanes_t st_out    [1:DEG];
  lanes_t slice_res [L];

  logic adv_c, beat_acc_c, out_hs_c, poly_rdy_c, load_c;

  // Stage k sits in slice (k-1)/FF_STEP; its first stage reads the previous slice register.
  for (genvar k = 1; k <= DEG; k++) begin : g_stage
    localparam int unsigned SIDX = (k - 1) / FF_STEP;
    if (k == 1) begin : g_head
      assign st_acc_in[k] = {PAR_NUM{coef_q[DEG]}};
    end else if ((k - 1) % FF_STEP == 0) begin : g_cut
      assign st_acc_in[k] = acc_q[SIDX-1];
    end else begin : g_chain
      assign st_acc_in[k] = st_out[k-1];
    end
    if (SIDX == 0) begin : g_x_in
      assign st_x[k] = bus.symb_i;
    end else begin : g_x_reg
      assign st_x[k] = x_q[SIDX-1];
    end
    gf_horner_stage #(.PAR_NUM(PAR_NUM)) u_stage (
      .coef_i (coef_q[DEG-k]),
      .acc_i  (st_acc_in[k]),
      .x_i    (st_x[k]),
      .acc_o  (st_out[k])
    );
  end

  for (genvar s = 0; s < L; s++) begin : g_slice
    localparam int unsigned SEND = slice_end(s, DEG, FF_STEP);
    assign slice_res[s] = st_out[SEND];
  end

  always_comb begin
    adv_c      = bus.eval_rdy_i | ~vld_q[L-1];
    beat_acc_c = bus.symb_vld_i & adv_c;
    out_hs_c   = vld_q[L-1] & bus.eval_rdy_i;
    poly_rdy_c = (cnt_q == '0) & ~bus.symb_vld_i;
    load_c     = bus.poly_vld_i & poly_rdy_c;
    coef_d     = coef_q;
    vld_d      = vld_q;
    last_d     = last_q;
    x_d        = x_q;
    acc_d      = acc_q;
    zero_d     = zero_q;
    cnt_d      = cnt_q + CNT_W'(beat_acc_c) - CNT_W'(out_hs_c);
    if (load_c) coef_d = bus.poly_i;
    // Every slice shifts together; a stalled output freezes the whole pipe.
    if (adv_c) begin
      vld_d[0]  = bus.symb_vld_i;
      last_d[0] = bus.symb_last_i;
      x_d[0]    = bus.symb_i;
      acc_d[0]  = slice_res[0];
      for (int s = 1; s < int'(L); s++) begin
        vld_d[s]  = vld_q[s-1];
        last_d[s] = last_q[s-1];
        x_d[s]    = x_q[s-1];
        acc_d[s]  = slice_res[s];
      end
      for (int p = 0; p < int'(PAR_NUM); p++) begin
        zero_d[p] = (slice_res[L-1][p] == '0);
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      coef_q <= '0;
      vld_q  <= '0;
      last_q <= '0;
      x_q    <= '{default: '0};
      acc_q  <= '{default: '0};
      zero_q <= '0;
      cnt_q  <= '0;
    end else begin
      coef_q <= coef_d;
      vld_q  <= vld_d;
      last_q <= last_d;
      x_q    <= x_d;
      acc_q  <= acc_d;
      zero_q <= zero_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.poly_rdy_o  = poly_rdy_c;
  assign bus.symb_rdy_o  = adv_c;
  assign bus.eval_vld_o  = vld_q[L-1];
  assign bus.eval_o      = acc_q[L-1];
  assign bus.eval_zero_o = zero_q;
  assign bus.eval_last_o = last_q[L-1];
  assign bus.busy_o      = (cnt_q != '0);

endmodule

// File: doc/gf_poly_eval_pipe.md
GF_POLY_EVAL_PIPE -- requirements
Module: gf_poly_eval_pipe

Interface
REQ-001 SHALL have parameter DEG, default T_LEN: maximum polynomial degree; legal range 1..T_LEN.
REQ-002 SHALL have parameter PAR_NUM, default 1: evaluation points per beat; legal range 1..16.
REQ-003 SHALL have parameter FF_STEP, default FF_STEP__CHIEN: Horner stages per register slice; legal range 1..DEG.
REQ-004 SHALL have port aclk, input, 1: sole clock; all state on rising edge.
REQ-005 SHALL have port areset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port poly_vld_i, input, 1: coefficient-load request.
REQ-007 SHALL have port poly_rdy_o, output, 1: coefficient load accepted this cycle when high with poly_vld_i.
REQ-008 SHALL have port poly_i, input, SYMB_WIDTH x (DEG+1): coefficients, index = power of x.
REQ-009 SHALL have port symb_vld_i, input, 1: evaluation-point beat valid.
REQ-010 SHALL have port symb_rdy_o, output, 1: beat accepted when high with symb_vld_i.
REQ-011 SHALL have port symb_i, input, SYMB_WIDTH x PAR_NUM: evaluation points.
REQ-012 SHALL have port symb_last_i, input, 1: last beat of a frame.
REQ-013 SHALL have port eval_vld_o, output, 1: result beat valid.
REQ-014 SHALL have port eval_rdy_i, input, 1: downstream ready.
REQ-015 SHALL have port eval_o, output, SYMB_WIDTH x PAR_NUM: poly(symb_i[p]) per lane p.
REQ-016 SHALL have port eval_zero_o, output, PAR_NUM: lane result equals zero (root flag).
REQ-017 SHALL have port eval_last_o, output, 1: symb_last_i delayed with its beat.
REQ-018 SHALL have port busy_o, output, 1: at least one beat in flight.

Function
REQ-019 Accepted poly_i SHALL be stored in a coefficient register and held until the next accepted load; coefficients are fully general (leading coefficient not assumed 1).
REQ-020 poly_rdy_o SHALL be high only when busy_o is low and symb_vld_i is low; a load never coincides with an accepted beat.
REQ-021 Evaluation SHALL be Horner: acc0 = c[DEG]; acc(k) = gf_mult(acc(k-1), x) xor c[DEG-k], k = 1..DEG; result acc(DEG).
REQ-022 A register slice SHALL follow every FF_STEP Horner stages and after stage DEG; latency L = ceil(DEG/FF_STEP) cycles from acceptance to eval_vld_o, with no backpressure.
REQ-023 Each slice SHALL carry valid, last, x per lane and partial acc per lane; x and coefficients travel unchanged.
REQ-024 The pipeline SHALL advance as a whole when eval_rdy_i is high or eval_vld_o is low; otherwise all slices hold.
REQ-025 symb_rdy_o SHALL equal the advance condition (full throughput: one beat per cycle with eval_rdy_i high).
REQ-026 eval_o, eval_zero_o and eval_last_o SHALL be stable while eval_vld_o is high and eval_rdy_i is low.
REQ-027 An in-flight counter (width clog2(L+2)) SHALL increment on beat acceptance, decrement on output handshake, and hold on both; busy_o = counter != 0.
REQ-028 Symbols equal to 0 SHALL yield c[0]; poly all-zero SHALL yield 0 with eval_zero_o all ones.
REQ-029 Output order SHALL equal input order; no beat dropped or duplicated.

Reset
REQ-030 While areset is high: all valid bits, counter, eval_vld_o, busy_o, eval_zero_o, eval_last_o SHALL be 0; coefficient register and eval_o 0; symb_rdy_o 1; poly_rdy_o 1.
REQ-031 Reset mid-frame SHALL discard all in-flight beats; first result after deassertion comes only from beats accepted afterward.

Structure
REQ-032 SYMB_WIDTH, T_LEN, FF_STEP__CHIEN and gf_mult SHALL come from gf_pkg; no local field arithmetic.
REQ-033 One sub-module gf_horner_stage (one coefficient, PAR_NUM lanes, combinational multiply-xor) SHALL be instantiated DEG times; slicing handled in the top.

Verification (GF(2^8), prim 0x11D, DEG=4, PAR_NUM=2, FF_STEP=2, L=2)
REQ-034 Load c={1,1,0,0,0}, symb={2,0} -> eval_o={3,1} after 2 cycles, eval_zero_o=00.
REQ-035 Load c={0,0,1,0,0}, symb={2,3} -> eval_o={4,5}; c={1,1,0,0,0}, symb={1,7} -> lane0 0, eval_zero_o[0]=1.
REQ-036 Ten back-to-back beats, eval_rdy_i low cycles 3-5 -> no loss, order kept, outputs stable during stall, symb_rdy_o low while stalled.
REQ-037 poly_vld_i asserted with busy_o high -> poly_rdy_o low until final result handshakes; then load accepted, results use new coefficients.
REQ-038 areset pulsed with 2 beats in flight -> eval_vld_o 0, busy_o 0 next cycle; no stale result ever emitted.
REQ-039 symb_last_i on beat 4 of 5 -> eval_last_o high only on output beat 4.
